// File: rtl/cpu_types_pkg.sv
// Types shared by the caches, the RAM model and the cache/memory arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and RAM-side handshake bundle around the cache/memory arbiter.
interface cache_mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // master: caches plus RAM (the environment); slave: the arbiter itself
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the single-ported RAM between icache and dcache; dcache wins by default,
// a saturating starvation counter forces an icache grant after STARVE_MAX dcache wins.
//
// state  | meaning
// IDLE   | no transaction, arbitrate pending requests
// DGRANT | dcache owns the RAM until ACCESS, ERROR or withdrawal
// IGRANT | icache owns the RAM until ACCESS, ERROR or withdrawal
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               CLK,
    input logic               nRST,
    cache_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    arb_state_t state, next_state;
    logic [2:0] starve_cnt, starve_nxt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        next_state   = state;
        starve_nxt   = starve_cnt;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;

        unique case (state)
            IDLE: begin
                if ((bus.dREN || bus.dWEN) && !(bus.iREN && starve_cnt == STARVE_LIM))
                    next_state = DGRANT;
                else if (bus.iREN)
                    next_state = IGRANT;
            end
            DGRANT: begin
                if (!(bus.dREN || bus.dWEN)) begin
                    next_state = IDLE;
                end else begin
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    if (bus.ramstate == ACCESS) begin
                        bus.dwait  = 1'b0;
                        next_state = IDLE;
                        if (bus.iREN && starve_cnt < STARVE_LIM)
                            starve_nxt = starve_cnt + 3'd1;
                    end else if (bus.ramstate == ERROR) begin
                        // retry happens through a fresh arbitration round
                        next_state = IDLE;
                    end
                end
            end
            IGRANT: begin
                if (!bus.iREN) begin
                    next_state = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait  = 1'b0;
                        next_state = IDLE;
                        starve_nxt = '0;
                    end else if (bus.ramstate == ERROR) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed-vector bench for cache_mem_arbiter; inputs change and outputs are
// checked just after the falling edge.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    int   vectors = 0;
    int   miscompares = 0;

    cache_mem_arbiter_if bus();

    cache_mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dcomp;
        int icomp;
        int cyc;

        // reset with both requests high
        nRST         = 1'b0;
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
        repeat (3) step();
        settle();
        check("rst_iwait",  32'(bus.iwait),  32'd1);
        check("rst_dwait",  32'(bus.dwait),  32'd1);
        check("rst_ramren", 32'(bus.ramREN), 32'd0);
        check("rst_ramwen", 32'(bus.ramWEN), 32'd0);
        check("rst_addr",   bus.ramaddr,     32'd0);
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        nRST     = 1'b1;
        step(); settle();
        check("post_rst_idle_ren", 32'(bus.ramREN), 32'd0);
        check("post_rst_starve",   32'(dut.starve_cnt), 32'd0);

        // single fetch: BUSY, BUSY, ACCESS
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
        settle();
        check("fetch_c0_ren", 32'(bus.ramREN), 32'd0);
        step(); settle();
        check("fetch_c1_addr",  bus.ramaddr,      32'h40);
        check("fetch_c1_ren",   32'(bus.ramREN),  32'd1);
        check("fetch_c1_iwait", 32'(bus.iwait),   32'd1);
        step(); settle();
        check("fetch_c2_addr",  bus.ramaddr,      32'h40);
        check("fetch_c2_iwait", 32'(bus.iwait),   32'd1);
        step();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        settle();
        check("fetch_c3_iwait", 32'(bus.iwait), 32'd0);
        check("fetch_c3_iload", bus.iload,      32'hDEADBEEF);
        check("fetch_c3_dwait", 32'(bus.dwait), 32'd1);
        step();
        bus.iREN = 1'b0;
        settle();
        check("fetch_c4_iwait", 32'(bus.iwait),  32'd1);
        check("fetch_c4_ren",   32'(bus.ramREN), 32'd0);

        // contention: dcache write first, then icache read
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        bus.ramstate = ACCESS; bus.ramload = 32'h5555;
        settle();
        check("cont_c0_wen", 32'(bus.ramWEN), 32'd0);
        step(); settle();
        check("cont_c1_wen",   32'(bus.ramWEN), 32'd1);
        check("cont_c1_ren",   32'(bus.ramREN), 32'd0);
        check("cont_c1_store", bus.ramstore,    32'h1234);
        check("cont_c1_addr",  bus.ramaddr,     32'h80);
        check("cont_c1_dwait", 32'(bus.dwait),  32'd0);
        check("cont_c1_iwait", 32'(bus.iwait),  32'd1);
        step();
        bus.dWEN = 1'b0;
        settle();
        check("cont_c2_ren",    32'(bus.ramREN),     32'd0);
        check("cont_c2_starve", 32'(dut.starve_cnt), 32'd1);
        step(); settle();
        check("cont_c3_ren",   32'(bus.ramREN), 32'd1);
        check("cont_c3_addr",  bus.ramaddr,     32'h44);
        check("cont_c3_store", bus.ramstore,    32'h0);
        check("cont_c3_iwait", 32'(bus.iwait),  32'd0);
        check("cont_c3_iload", bus.iload,       32'h5555);
        step();
        bus.iREN = 1'b0;
        settle();
        check("cont_starve_clr", 32'(dut.starve_cnt), 32'd0);

        // starvation: iREN held, dREN continuous, immediate ACCESS
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h200;
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        bus.ramstate = ACCESS; bus.ramload = 32'hA5;
        dcomp = 0; icomp = 0; cyc = 0;
        while (icomp == 0 && cyc < 40) begin
            settle();
            if (bus.dwait == 1'b0) dcomp++;
            if (bus.iwait == 1'b0) begin
                icomp++;
                check("starve_iaddr", bus.ramaddr, 32'h200);
            end
            cyc++;
            if (icomp == 0) step();
        end
        check("starve_icomp", 32'(icomp), 32'd1);
        check("starve_dcomp", 32'(dcomp), 32'd4);
        step();
        bus.iREN = 1'b0; bus.dREN = 1'b0;
        settle();
        check("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);

        // ERROR then retry with ACCESS
        step();
        bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = ERROR;
        settle();
        check("err_c0_ren", 32'(bus.ramREN), 32'd0);
        step(); settle();
        check("err_c1_ren",   32'(bus.ramREN), 32'd1);
        check("err_c1_dwait", 32'(bus.dwait),  32'd1);
        step();
        bus.ramstate = ACCESS; bus.ramload = 32'h77;
        settle();
        check("err_c2_idle",  32'(bus.ramREN), 32'd0);
        check("err_c2_dwait", 32'(bus.dwait),  32'd1);
        step(); settle();
        check("err_c3_dwait", 32'(bus.dwait), 32'd0);
        check("err_c3_dload", bus.dload,      32'h77);
        check("err_c3_addr",  bus.ramaddr,    32'h300);
        step();
        bus.dREN = 1'b0;
        settle();

        // withdrawal during BUSY
        step();
        bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = BUSY;
        step(); settle();
        check("wd_c1_ren", 32'(bus.ramREN), 32'd1);
        step();
        bus.dREN = 1'b0;
        settle();
        check("wd_c2_ren",   32'(bus.ramREN), 32'd0);
        check("wd_c2_addr",  bus.ramaddr,     32'h0);
        check("wd_c2_dwait", 32'(bus.dwait),  32'd1);
        step(); settle();
        check("wd_c3_ren",   32'(bus.ramREN), 32'd0);
        check("wd_c3_iwait", 32'(bus.iwait),  32'd1);
        check("wd_c3_dwait", 32'(bus.dwait),  32'd1);

        // asynchronous reset pulse inside IGRANT
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = BUSY;
        step(); settle();
        check("mrst_pre_ren", 32'(bus.ramREN), 32'd1);
        #1 nRST = 1'b0;
        #1;
        check("mrst_ren",   32'(bus.ramREN), 32'd0);
        check("mrst_addr",  bus.ramaddr,     32'h0);
        check("mrst_iwait", 32'(bus.iwait),  32'd1);
        bus.iREN = 1'b0;
        step();
        nRST = 1'b1;
        step(); settle();
        check("mrst_post_ren",    32'(bus.ramREN),     32'd0);
        check("mrst_post_starve", 32'(dut.starve_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
